// File: rtl/opfetch_pkg.sv
// Shared constants, output-stage state and operand bundle for the operand-fetch stage.
package opfetch_pkg;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned AW     = 3;
    localparam int unsigned NREG   = 1 << AW;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic {
        StEmpty,
        StFull
    } ostate_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [AW-1:0]     rd;
        logic              wr_rd;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } bundle_t;

    function automatic logic [NREG-1:0] addr_onehot(input logic [AW-1:0] addr, input logic en);
        addr_onehot = en ? (NREG'(1) << addr) : '0;
    endfunction

endpackage

// File: rtl/opfetch_scoreboard.sv
// Pending-write scoreboard with a three-address hazard check.
// OPFETCH_BYPASS_EN lets a same-cycle clear release the hazard on that register.
module opfetch_scoreboard
    import opfetch_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          set_en_i,
    input  logic [AW-1:0] set_addr_i,
    input  logic          clr_en_i,
    input  logic [AW-1:0] clr_addr_i,
    input  logic          chk1_en_i,
    input  logic [AW-1:0] chk1_addr_i,
    input  logic          chk2_en_i,
    input  logic [AW-1:0] chk2_addr_i,
    input  logic          chk3_en_i,
    input  logic [AW-1:0] chk3_addr_i,
    output logic          hazard_o
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [NREG-1:0] pending_chk;

    // Clear first, then set, so a colliding set wins.
    always_comb begin
        pending_d = pending_q & ~addr_onehot(clr_addr_i, clr_en_i);
        pending_d = pending_d | addr_onehot(set_addr_i, set_en_i);
    end

`ifdef OPFETCH_BYPASS_EN
    assign pending_chk = pending_q & ~addr_onehot(clr_addr_i, clr_en_i);
`else
    assign pending_chk = pending_q;
`endif

    assign hazard_o = (chk1_en_i & pending_chk[chk1_addr_i])
                    | (chk2_en_i & pending_chk[chk2_addr_i])
                    | (chk3_en_i & pending_chk[chk3_addr_i]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Issue/operand-fetch stage: hazard-checked issue into a one-entry operand output register.
// OPFETCH_BYPASS_EN forwards same-cycle writeback data and releases matching hazards.
module operand_fetch
    import opfetch_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [OP_W-1:0]   in_op_i,
    input  logic [AW-1:0]     in_rd_i,
    input  logic [AW-1:0]     in_rs1_i,
    input  logic [AW-1:0]     in_rs2_i,
    input  logic              in_use_rs1_i,
    input  logic              in_use_rs2_i,
    input  logic              in_wr_rd_i,
    input  logic [DATA_W-1:0] in_imm_i,
    output logic [AW-1:0]     rf_sel_1_o,
    output logic [AW-1:0]     rf_sel_2_o,
    input  logic [DATA_W-1:0] rf_data_1_i,
    input  logic [DATA_W-1:0] rf_data_2_i,
    input  logic              wb_valid_i,
    input  logic [AW-1:0]     wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OP_W-1:0]   out_op_o,
    output logic [AW-1:0]     out_rd_o,
    output logic              out_wr_rd_o,
    output logic [DATA_W-1:0] out_a_o,
    output logic [DATA_W-1:0] out_b_o,
    output logic              hazard_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    ostate_e          state_q, state_d;
    bundle_t          out_q, out_d, bundle_in;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             sb_hazard, hazard, issue, fwd_1, fwd_2;
    logic [DATA_W-1:0] src_1, src_2;

    opfetch_scoreboard u_sb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .set_en_i    (issue & in_wr_rd_i),
        .set_addr_i  (in_rd_i),
        .clr_en_i    (wb_valid_i & ~rst_i),
        .clr_addr_i  (wb_addr_i),
        .chk1_en_i   (in_use_rs1_i),
        .chk1_addr_i (in_rs1_i),
        .chk2_en_i   (in_use_rs2_i),
        .chk2_addr_i (in_rs2_i),
        .chk3_en_i   (in_wr_rd_i),
        .chk3_addr_i (in_rd_i),
        .hazard_o    (sb_hazard)
    );

    assign hazard     = ~rst_i & in_valid_i & sb_hazard;
    assign in_ready_o = ~rst_i & ~hazard & (state_q == StEmpty | out_ready_i);
    assign issue      = in_valid_i & in_ready_o;

    assign rf_sel_1_o = in_rs1_i;
    assign rf_sel_2_o = in_rs2_i;

`ifdef OPFETCH_BYPASS_EN
    assign fwd_1 = wb_valid_i & (wb_addr_i == in_rs1_i);
    assign fwd_2 = wb_valid_i & (wb_addr_i == in_rs2_i);
`else
    assign fwd_1 = 1'b0;
    assign fwd_2 = 1'b0;
`endif

    assign src_1 = fwd_1 ? wb_data_i : rf_data_1_i;
    assign src_2 = fwd_2 ? wb_data_i : rf_data_2_i;

    always_comb begin
        bundle_in.op    = in_op_i;
        bundle_in.rd    = in_rd_i;
        bundle_in.wr_rd = in_wr_rd_i;
        bundle_in.a     = in_use_rs1_i ? src_1 : '0;
        bundle_in.b     = in_use_rs2_i ? src_2 : in_imm_i;
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        unique case (state_q)
            StEmpty: begin
                if (issue) begin
                    state_d = StFull;
                    out_d   = bundle_in;
                end
            end
            StFull: begin
                if (out_ready_i) begin
                    if (issue) begin
                        out_d = bundle_in;
                    end else begin
                        state_d = StEmpty;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    assign stall_d = (hazard && stall_q != '1) ? stall_q + 1'b1 : stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            out_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            stall_q <= stall_d;
        end
    end

    assign out_valid_o = (state_q == StFull);
    assign out_op_o    = out_q.op;
    assign out_rd_o    = out_q.rd;
    assign out_wr_rd_o = out_q.wr_rd;
    assign out_a_o     = out_q.a;
    assign out_b_o     = out_q.b;
    assign hazard_o    = hazard;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic
// against a scoreboard/queue model. Honours OPFETCH_BYPASS_EN if defined globally.
`timescale 1ns/1ps
module tb_operand_fetch;
    import opfetch_pkg::*;

`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, in_valid, in_ready, in_use_rs1, in_use_rs2, in_wr_rd;
    logic [OP_W-1:0]   in_op, out_op;
    logic [AW-1:0]     in_rd, in_rs1, in_rs2, rf_sel_1, rf_sel_2, wb_addr, out_rd;
    logic [DATA_W-1:0] in_imm, rf_data_1, rf_data_2, wb_data, out_a, out_b;
    logic              wb_valid, out_valid, out_ready, out_wr_rd, hazard;
    logic [CNT_W-1:0]  stall_cnt;

    // Register file owned by the bench, written from the writeback bus.
    logic [DATA_W-1:0] rf [NREG];
    assign rf_data_1 = rf[rf_sel_1];
    assign rf_data_2 = rf[rf_sel_2];

    operand_fetch dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_op_i(in_op), .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
        .in_use_rs1_i(in_use_rs1), .in_use_rs2_i(in_use_rs2), .in_wr_rd_i(in_wr_rd),
        .in_imm_i(in_imm), .rf_sel_1_o(rf_sel_1), .rf_sel_2_o(rf_sel_2),
        .rf_data_1_i(rf_data_1), .rf_data_2_i(rf_data_2), .wb_valid_i(wb_valid),
        .wb_addr_i(wb_addr), .wb_data_i(wb_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_op_o(out_op), .out_rd_o(out_rd),
        .out_wr_rd_o(out_wr_rd), .out_a_o(out_a), .out_b_o(out_b), .hazard_o(hazard),
        .stall_cnt_o(stall_cnt)
    );

    // Reference model state.
    logic [NREG-1:0]  m_pend;
    logic             m_full;
    bundle_t          m_out;
    logic [CNT_W-1:0] m_stall;
    int n_tests = 0;
    int n_fail  = 0;

    function automatic bit m_busy(input logic [AW-1:0] r);
        return m_pend[r] && !(BYP && wb_valid && wb_addr == r);
    endfunction

    function automatic bit m_hazard();
        if (rst || !in_valid) return 1'b0;
        return (in_use_rs1 && m_busy(in_rs1)) || (in_use_rs2 && m_busy(in_rs2)) ||
               (in_wr_rd && m_busy(in_rd));
    endfunction

    function automatic bit m_ready();
        return !rst && !m_hazard() && (!m_full || out_ready);
    endfunction

    function automatic logic [DATA_W-1:0] m_src(input logic [AW-1:0] r);
        return (BYP && wb_valid && wb_addr == r) ? wb_data : rf[r];
    endfunction

    function automatic bundle_t dut_out();
        return {out_op, out_rd, out_wr_rd, out_a, out_b};
    endfunction

    // Advance one clock, stepping the model from the inputs held before the edge.
    task automatic tick();
        bit iss, hz, wupd;
        bundle_t nb;
        logic [NREG-1:0] np;
        logic nf;
        logic [CNT_W-1:0] ns;
        logic [AW-1:0] wa;
        logic [DATA_W-1:0] wd;
        hz = m_hazard();
        iss = in_valid && m_ready();
        nb = m_out; np = m_pend; nf = m_full; ns = m_stall;
        wupd = !rst && wb_valid; wa = wb_addr; wd = wb_data;
        if (rst) begin
            nb = '0; np = '0; nf = 1'b0; ns = '0;
        end else begin
            if (iss) begin
                nb.op = in_op; nb.rd = in_rd; nb.wr_rd = in_wr_rd;
                nb.a = in_use_rs1 ? m_src(in_rs1) : '0;
                nb.b = in_use_rs2 ? m_src(in_rs2) : in_imm;
                nf = 1'b1;
            end else if (out_ready) begin
                nf = 1'b0;
            end
            if (wb_valid) np[wb_addr] = 1'b0;
            if (iss && in_wr_rd) np[in_rd] = 1'b1;
            if (hz && ns != '1) ns = ns + 1'b1;
        end
        @(posedge clk);
        #1;
        m_out = nb; m_pend = np; m_full = nf; m_stall = ns;
        if (wupd) rf[wa] = wd;
    endtask

    task automatic idle();
        in_valid = 0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_use_rs1 = 0; in_use_rs2 = 0; in_wr_rd = 0; in_imm = '0;
        wb_valid = 0; wb_addr = '0; wb_data = '0; out_ready = 1;
    endtask

    task automatic test_reset();
        idle(); rst = 1; in_valid = 1; in_use_rs1 = 1; in_rs1 = 3'd1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b want 0", hazard); end
        tick(); tick();
        rst = 0; in_valid = 0; #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (dut_out() !== '0) begin n_fail++; $display("FAIL reset_bundle: got %h want 0", dut_out()); end
        n_tests++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_basic();
        idle(); rf[1] = 24'd9; rf[2] = 24'd1;
        in_valid = 1; in_op = 6'h15; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2;
        in_use_rs1 = 1; in_use_rs2 = 1; in_wr_rd = 1; in_imm = 24'h777777;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        n_tests++; if (rf_sel_1 !== 3'd1 || rf_sel_2 !== 3'd2) begin n_fail++; $display("FAIL basic_sel: got %0d/%0d want 1/2", rf_sel_1, rf_sel_2); end
        tick();
        in_valid = 0; #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
        n_tests++; if (out_a !== 24'd9 || out_b !== 24'd1) begin n_fail++; $display("FAIL basic_operands: got %h/%h want 9/1", out_a, out_b); end
        n_tests++; if (dut_out() !== m_out) begin n_fail++; $display("FAIL basic_bundle: got %h want %h", dut_out(), m_out); end
        in_valid = 1; in_wr_rd = 0; in_use_rs2 = 0; in_rs1 = 3'd3; #1;
        n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL basic_pending3: hazard %b want 1", hazard); end
        in_valid = 0; wb_valid = 1; wb_addr = 3'd3; wb_data = 24'h000033;
        tick();
        wb_valid = 0;
    endtask

    task automatic test_raw();
        int hz_cnt = 0;
        int iss_cyc = -1;
        logic [CNT_W-1:0] stall0;
        idle(); in_valid = 1; in_rd = 3'd3; in_wr_rd = 1;
        tick();
        in_rd = 3'd4; in_wr_rd = 0; in_use_rs1 = 1; in_rs1 = 3'd3; in_imm = 24'h000042;
        stall0 = m_stall;
        for (int c = 0; c < 12 && iss_cyc < 0; c++) begin
            wb_valid = (c == 4); wb_addr = 3'd3; wb_data = 24'h00ABCD;
            #1;
            n_tests++; if (hazard !== m_hazard()) begin n_fail++; $display("FAIL raw_hazard c%0d: got %b want %b", c, hazard, m_hazard()); end
            if (hazard) hz_cnt++;
            if (in_ready) iss_cyc = c;
            tick();
        end
        idle(); #1;
        n_tests++; if (hz_cnt != (BYP ? 4 : 5)) begin n_fail++; $display("FAIL raw_stall_cycles: got %0d want %0d", hz_cnt, BYP ? 4 : 5); end
        n_tests++; if (iss_cyc != (BYP ? 4 : 5)) begin n_fail++; $display("FAIL raw_issue_cycle: got %0d want %0d", iss_cyc, BYP ? 4 : 5); end
        n_tests++; if (stall_cnt !== stall0 + CNT_W'(BYP ? 4 : 5)) begin n_fail++; $display("FAIL raw_stall_cnt: got %0d want %0d", stall_cnt, stall0 + CNT_W'(BYP ? 4 : 5)); end
        n_tests++; if (out_valid !== 1'b1 || out_a !== 24'h00ABCD) begin n_fail++; $display("FAIL raw_out_a: got v%b %h want v1 00abcd", out_valid, out_a); end
        tick();
    endtask

    task automatic test_imm();
        idle(); in_valid = 1; in_use_rs1 = 1; in_rs1 = 3'd1; in_imm = 24'h123456;
        tick();
        in_use_rs1 = 0; in_imm = 24'h0F0F0F; #1;
        n_tests++; if (out_b !== 24'h123456) begin n_fail++; $display("FAIL imm_b: got %h want 123456", out_b); end
        n_tests++; if (out_a !== rf[1]) begin n_fail++; $display("FAIL imm_a_rs1: got %h want %h", out_a, rf[1]); end
        tick();
        in_valid = 0; #1;
        n_tests++; if (out_a !== '0 || out_b !== 24'h0F0F0F) begin n_fail++; $display("FAIL imm_a_zero: got %h/%h want 0/0f0f0f", out_a, out_b); end
        tick();
    endtask

    task automatic test_back_to_back();
        idle(); in_valid = 1; in_op = 6'd1; in_imm = 24'h111111;
        tick();
        out_ready = 0; in_op = 6'd2; in_imm = 24'h222222;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
            n_tests++; if (out_valid !== 1'b1 || out_op !== 6'd1 || out_b !== 24'h111111) begin n_fail++; $display("FAIL bp_stable c%0d: got v%b op%0d %h want v1 op1 111111", c, out_valid, out_op, out_b); end
            tick();
        end
        out_ready = 1; #1;
        n_tests++; if (in_ready !== 1'b1 || out_op !== 6'd1) begin n_fail++; $display("FAIL bp_release: rdy %b op %0d want 1/1", in_ready, out_op); end
        tick();
        in_valid = 0; #1;
        n_tests++; if (out_valid !== 1'b1 || out_op !== 6'd2 || out_b !== 24'h222222) begin n_fail++; $display("FAIL bp_second: got v%b op%0d %h want v1 op2 222222", out_valid, out_op, out_b); end
        tick();
    endtask

    task automatic test_waw_r0();
        int hz_cnt = 0;
        int iss_cyc = -1;
        idle(); in_valid = 1; in_rd = 3'd0; in_wr_rd = 1; in_op = 6'd7;
        tick();
        in_op = 6'd8;
        for (int c = 0; c < 10 && iss_cyc < 0; c++) begin
            wb_valid = (c == 1) || (c == 2); wb_addr = (c == 1) ? 3'd5 : 3'd0;
            wb_data = 24'h000500;
            #1;
            n_tests++; if (hazard !== m_hazard()) begin n_fail++; $display("FAIL waw_hazard c%0d: got %b want %b", c, hazard, m_hazard()); end
            if (hazard) hz_cnt++;
            if (in_ready) iss_cyc = c;
            tick();
        end
        wb_valid = 0; in_wr_rd = 0; #1;
        n_tests++; if (hz_cnt != (BYP ? 2 : 3)) begin n_fail++; $display("FAIL waw_stall_cycles: got %0d want %0d", hz_cnt, BYP ? 2 : 3); end
        n_tests++; if (out_op !== 6'd8 || out_rd !== 3'd0 || out_wr_rd !== 1'b1) begin n_fail++; $display("FAIL waw_out: got op%0d rd%0d w%b want op8 rd0 w1", out_op, out_rd, out_wr_rd); end
        in_use_rs1 = 1; in_rs1 = 3'd5; #1;
        n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL waw_stray_wb: pending5 hazard %b want 0", hazard); end
        in_rs1 = 3'd0; #1;
        n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL waw_pending0: hazard %b want 1", hazard); end
        idle(); wb_valid = 1; wb_addr = 3'd0;
        tick();
        wb_valid = 0;
    endtask

    task automatic test_random();
        int start;
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_op = OP_W'($urandom); in_rd = AW'($urandom); in_rs1 = AW'($urandom);
            in_rs2 = AW'($urandom); in_use_rs1 = 1'($urandom); in_use_rs2 = 1'($urandom);
            in_wr_rd = 1'($urandom); in_imm = DATA_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid = ($urandom_range(0, 2) == 0); wb_data = DATA_W'($urandom);
            wb_addr = AW'($urandom);
            start = $urandom_range(0, NREG - 1);
            for (int k = 0; k < NREG; k++) begin
                if (m_pend[(start + k) % NREG]) wb_addr = AW'((start + k) % NREG);
            end
            #1;
            n_tests++; if (hazard !== m_hazard()) begin n_fail++; $display("FAIL rnd_hazard c%0d: got %b want %b", c, hazard, m_hazard()); end
            n_tests++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, m_ready()); end
            n_tests++; if (out_valid !== m_full) begin n_fail++; $display("FAIL rnd_out_valid c%0d: got %b want %b", c, out_valid, m_full); end
            n_tests++; if (stall_cnt !== m_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0d want %0d", c, stall_cnt, m_stall); end
            if (m_full) begin
                n_tests++; if (dut_out() !== m_out) begin n_fail++; $display("FAIL rnd_bundle c%0d: got %h want %h", c, dut_out(), m_out); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        idle();
        for (int r = 0; r < NREG; r++) begin
            if (m_pend[r]) begin
                wb_valid = 1; wb_addr = AW'(r);
                tick();
            end
        end
        idle(); in_valid = 1; in_rd = 3'd3; in_wr_rd = 1; in_imm = 24'h0000AA;
        tick();
        in_valid = 0; out_ready = 0; #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_full: got %b want 1", out_valid); end
        rst = 1; wb_valid = 1; wb_addr = 3'd6; wb_data = 24'hDEAD00;
        tick();
        rst = 0; wb_valid = 0; #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        n_tests++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL rmid_stall: got %0d want 0", stall_cnt); end
        n_tests++; if (dut_out() !== '0) begin n_fail++; $display("FAIL rmid_bundle: got %h want 0", dut_out()); end
        in_valid = 1; in_wr_rd = 0; in_use_rs1 = 1;
        for (int r = 0; r < NREG; r++) begin
            in_rs1 = AW'(r); #1;
            n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL rmid_pending%0d: hazard %b want 0", r, hazard); end
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) rf[r] = DATA_W'($urandom);
        m_pend = '0; m_full = 1'b0; m_out = '0; m_stall = '0;
        rst = 1; idle();
        test_reset();
        test_basic();
        test_raw();
        test_imm();
        test_back_to_back();
        test_waw_r0();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
